// File: rtl/voice_engine.sv
// voice_engine: polyphonic wavetable voice mixer with a per-key ADSR envelope,
// scanning all keys once per SAMPLE_TICK and emitting one saturated mix per frame.
module voice_engine #(
  parameter int NUM_KEYS = 128,
  parameter int KEY_W    = 7,
  parameter int PHASE_W  = 24,
  parameter int ADDR_W   = 12,
  parameter int SAMPLE_W = 16,
  parameter int AMP_W    = 21,
  parameter int MIX_W    = 32
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       SAMPLE_TICK,
  input  logic                       WAVE_SEL,
  input  logic                       AVL_WE,
  input  logic [KEY_W-1:0]           AVL_KEY,
  input  logic [6:0]                 AVL_VEL,
  input  logic [AMP_W-1:0]           PEAK_ATT,
  input  logic [AMP_W-1:0]           ATT_STEP,
  input  logic [AMP_W-1:0]           DEC_STEP,
  input  logic [AMP_W-1:0]           PEAK_SUS,
  input  logic [AMP_W-1:0]           SUS_STEP,
  input  logic [AMP_W-1:0]           REL_STEP,
  output logic [KEY_W-1:0]           SCAN_KEY,
  input  logic [PHASE_W-1:0]         FREQ_INC,
  output logic [ADDR_W:0]            WAVE_ADDR,
  input  logic signed [SAMPLE_W-1:0] WAVE_DATA,
  output logic [6:0]                 AVL_READVEL,
  output logic signed [MIX_W-1:0]    MIX,
  output logic                       MIX_VALID,
  output logic                       BUSY,
  output logic                       OVERRUN
);
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_MAC, S_DONE} state_t;
  typedef enum logic [2:0] {E_IDLE, E_ATTACK, E_DECAY, E_SUSTAIN, E_RELEASE} env_t;

  state_t                     state_q, state_d;
  logic [KEY_W-1:0]           key_q, key_d;
  logic signed [MIX_W-1:0]    acc_q, acc_d, mix_q;
  logic                       mix_valid_q, overrun_q;
  logic [6:0]                 readvel_q, vel_lat_q;
  logic [ADDR_W:0]            wave_addr_q;
  env_t                       env_st_q;
  logic [AMP_W-1:0]           env_amp_q;

  logic [6:0]                 vel_q   [NUM_KEYS];
  env_t                       st_q    [NUM_KEYS];
  logic [AMP_W-1:0]           amp_q   [NUM_KEYS];
  logic [PHASE_W-1:0]         phase_q [NUM_KEYS];

  env_t                       cur_st, nxt_st;
  logic [AMP_W-1:0]           cur_amp, nxt_amp;
  logic [AMP_W:0]             att_sum, dec_lim;
  logic                       gate, skip, last;
  logic [15:0]                gain;
  logic signed [MIX_W-1:0]    wd_x, gn_x, contrib, sat;
  logic signed [MIX_W:0]      sum;

  assign SCAN_KEY    = key_q;
  assign WAVE_ADDR   = wave_addr_q;
  assign AVL_READVEL = readvel_q;
  assign MIX         = mix_q;
  assign MIX_VALID   = mix_valid_q;
  assign BUSY        = state_q != S_IDLE;
  assign OVERRUN     = overrun_q;

  // Envelope step for the key under FETCH; IDLE always holds amp 0, so gate-on
  // from IDLE or RELEASE is an attack step from the stored amplitude.
  always_comb begin
    cur_st  = st_q[key_q];
    cur_amp = amp_q[key_q];
    gate    = vel_q[key_q] != 7'd0;
    skip    = cur_st == E_IDLE && !gate;
    att_sum = {1'b0, cur_amp} + {1'b0, ATT_STEP};
    dec_lim = {1'b0, PEAK_SUS} + {1'b0, DEC_STEP};
    nxt_st  = cur_st;
    nxt_amp = cur_amp;
    if (gate && (cur_st == E_IDLE || cur_st == E_ATTACK || cur_st == E_RELEASE)) begin
      nxt_st  = att_sum >= {1'b0, PEAK_ATT} ? E_DECAY : E_ATTACK;
      nxt_amp = att_sum >= {1'b0, PEAK_ATT} ? PEAK_ATT : att_sum[AMP_W-1:0];
    end else if (!gate && cur_st != E_IDLE) begin
      nxt_st  = cur_st != E_RELEASE ? E_RELEASE : cur_amp < REL_STEP ? E_IDLE : E_RELEASE;
      nxt_amp = cur_st != E_RELEASE ? cur_amp : cur_amp < REL_STEP ? '0 : cur_amp - REL_STEP;
    end else if (cur_st == E_DECAY) begin
      nxt_st  = {1'b0, cur_amp} <= dec_lim ? E_SUSTAIN : E_DECAY;
      nxt_amp = {1'b0, cur_amp} <= dec_lim ? PEAK_SUS : cur_amp - DEC_STEP;
    end else if (cur_st == E_SUSTAIN) begin
      nxt_amp = cur_amp < SUS_STEP ? '0 : cur_amp - SUS_STEP;
    end
  end

  // Voice contribution and saturating accumulate, evaluated in MAC
  always_comb begin
    gain    = 16'(((AMP_W+7)'(env_amp_q) * (AMP_W+7)'(vel_lat_q)) >> (AMP_W-9));
    wd_x    = {{(MIX_W-SAMPLE_W){WAVE_DATA[SAMPLE_W-1]}}, WAVE_DATA};
    gn_x    = {{(MIX_W-16){1'b0}}, gain};
    contrib = wd_x * gn_x;
    sum     = {acc_q[MIX_W-1], acc_q} + {contrib[MIX_W-1], contrib};
    sat     = sum[MIX_W] == sum[MIX_W-1] ? sum[MIX_W-1:0] :
              sum[MIX_W] ? {1'b1, {(MIX_W-1){1'b0}}} : {1'b0, {(MIX_W-1){1'b1}}};
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    acc_d   = acc_q;
    last    = key_q == KEY_W'(NUM_KEYS-1);
    case (state_q)
      S_IDLE: if (SAMPLE_TICK) begin
        state_d = S_FETCH;
        key_d   = '0;
        acc_d   = '0;
      end
      S_FETCH: begin
        state_d = !skip ? S_MAC : last ? S_DONE : S_FETCH;
        key_d   = skip ? key_q + 1'b1 : key_q;
      end
      S_MAC: begin
        acc_d   = sat;
        state_d = last ? S_DONE : S_FETCH;
        key_d   = key_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      key_q       <= '0;
      acc_q       <= '0;
      mix_q       <= '0;
      mix_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      readvel_q   <= '0;
      vel_lat_q   <= '0;
      wave_addr_q <= '0;
      env_st_q    <= E_IDLE;
      env_amp_q   <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        vel_q[i]   <= '0;
        st_q[i]    <= E_IDLE;
        amp_q[i]   <= '0;
        phase_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      acc_q       <= acc_d;
      mix_valid_q <= state_q == S_DONE;
      readvel_q   <= vel_q[AVL_KEY];
      if (state_q == S_DONE) mix_q <= acc_q;
      if (SAMPLE_TICK && state_q != S_IDLE) overrun_q <= 1'b1;
      if (AVL_WE) vel_q[AVL_KEY] <= AVL_VEL;
      if (state_q == S_FETCH && !skip) begin
        wave_addr_q    <= {WAVE_SEL, phase_q[key_q][PHASE_W-1 -: ADDR_W]};
        phase_q[key_q] <= nxt_st == E_IDLE ? '0 : phase_q[key_q] + FREQ_INC;
        env_st_q       <= nxt_st;
        env_amp_q      <= nxt_amp;
        vel_lat_q      <= vel_q[key_q];
      end
      if (state_q == S_MAC) begin
        st_q[key_q]  <= env_st_q;
        amp_q[key_q] <= env_amp_q;
      end
    end
  end
endmodule
